// File: rtl/chain_toggle_counter_bank.sv
// Bank of NCH ripple-toggle counters sharing one hold/enable and qualifier. Terminal-count
// events go through a 1-deep valid/ready stage. Define COUNTER_SAT_EN for saturating counts.
module chain_toggle_counter_bank #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned QUAL_W = 6,
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [QUAL_W-1:0]      qual,
  input  logic [NCH-1:0]         clr,
  input  logic [NCH-1:0]         bypass,
  output logic [NCH*WIDTH-1:0]   cnt_o,
  output logic                   tc_valid,
  output logic [CH_W-1:0]        tc_ch,
  input  logic                   tc_ready,
  output logic [NCH-1:0]         ovf_o
);

  logic [NCH-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [NCH-1:0]            ovf_q, ovf_d;
  logic [NCH-1:0]            take;
  logic [NCH-1:0]            ev;
  logic [WIDTH-1:0]          tmask;
  logic [CH_W-1:0]           sel;
  logic                      found;
  logic                      step;
  logic                      load;

  always_comb begin
    step  = en & ~(|qual);
    load  = ~tc_valid | tc_ready;
    found = 1'b0;
    sel   = '0;
    take  = '0;
    // A channel being cleared this cycle is not offered to the output stage.
    for (int c = 0; c < NCH; c++) begin
      if (!found && pend_q[c] && !clr[c]) begin
        found   = 1'b1;
        sel     = CH_W'(c);
        take[c] = load;
      end
    end

    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    ev     = '0;
    tmask  = '0;
    for (int c = 0; c < NCH; c++) begin
      // Ripple toggle: bit i flips when every lower bit is one.
      tmask[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
        tmask[i] = tmask[i-1] & cnt_q[c][i-1];
      end
      if (clr[c]) begin
        cnt_d[c] = '0;
      end else if (step && bypass[c]) begin
        cnt_d[c] = ~cnt_q[c];
      end else if (step) begin
`ifdef COUNTER_SAT_EN
        if (!(&cnt_q[c])) begin
          cnt_d[c] = cnt_q[c] ^ tmask;
          ev[c]    = (&cnt_q[c][WIDTH-1:1]) & ~cnt_q[c][0];
        end
`else
        cnt_d[c] = cnt_q[c] ^ tmask;
        ev[c]    = &cnt_q[c];
`endif
      end

      if (clr[c]) begin
        pend_d[c] = 1'b0;
        ovf_d[c]  = 1'b0;
      end else if (ev[c]) begin
        pend_d[c] = 1'b1;
        if (pend_q[c] && !take[c]) ovf_d[c] = 1'b1;
      end else if (take[c]) begin
        pend_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pend_q   <= '0;
      ovf_q    <= '0;
      tc_valid <= 1'b0;
      tc_ch    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (load) begin
        tc_valid <= found;
        if (found) tc_ch <= sel;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_chain_toggle_counter_bank.sv
// Randomized and directed bench for chain_toggle_counter_bank against an arithmetic model.
module tb_chain_toggle_counter_bank;
  localparam int NCH = 4;
  localparam int WIDTH = 8;
  localparam int QUAL_W = 6;
  localparam int CH_W = 2;
  localparam int MAX = (1 << WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [QUAL_W-1:0]    qual = '0;
  logic [NCH-1:0]       clr = '0;
  logic [NCH-1:0]       bypass = '0;
  logic [NCH*WIDTH-1:0] cnt_o;
  logic                 tc_valid;
  logic [CH_W-1:0]      tc_ch;
  logic                 tc_ready = 1'b0;
  logic [NCH-1:0]       ovf_o;

  chain_toggle_counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .QUAL_W(QUAL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .qual     (qual),
    .clr      (clr),
    .bypass   (bypass),
    .cnt_o    (cnt_o),
    .tc_valid (tc_valid),
    .tc_ch    (tc_ch),
    .tc_ready (tc_ready),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  // Reference state: plain integers and flags.
  int m_cnt [NCH];
  bit m_pend[NCH];
  bit m_ovf [NCH];
  bit m_v;
  int m_ch;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
    end
    m_v = 0; m_ch = 0;
  endtask

  task automatic model_step();
    bit step, load, ev, taken;
    int sel;
    step = en && (qual == 0);
    load = !m_v || tc_ready;
    sel = -1;
    for (int c = 0; c < NCH; c++)
      if (sel < 0 && m_pend[c] && !clr[c]) sel = c;
    if (load) begin
      m_v = (sel >= 0);
      if (sel >= 0) m_ch = sel;
    end
    for (int c = 0; c < NCH; c++) begin
      ev = 0;
      taken = load && (sel == c);
      if (clr[c]) begin
        m_cnt[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
      end else begin
        if (step && bypass[c]) m_cnt[c] = MAX - m_cnt[c];
        else if (step) begin
`ifdef COUNTER_SAT_EN
          if (m_cnt[c] < MAX) begin
            m_cnt[c] = m_cnt[c] + 1;
            ev = (m_cnt[c] == MAX);
          end
`else
          ev = (m_cnt[c] == MAX);
          m_cnt[c] = (m_cnt[c] + 1) % (MAX + 1);
`endif
        end
        if (ev) begin
          if (m_pend[c] && !taken) m_ovf[c] = 1;
          m_pend[c] = 1;
        end else if (taken) m_pend[c] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NCH*WIDTH-1:0] exp_cnt;
    logic [NCH-1:0] exp_ovf;
    for (int c = 0; c < NCH; c++) begin
      exp_cnt[c*WIDTH +: WIDTH] = WIDTH'(m_cnt[c]);
      exp_ovf[c] = m_ovf[c];
    end
    check("cnt", 64'(cnt_o), 64'(exp_cnt));
    check("tc_valid", 64'(tc_valid), 64'(m_v));
    if (m_v) check("tc_ch", 64'(tc_ch), 64'(m_ch));
    check("ovf", 64'(ovf_o), 64'(exp_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_cnt", 64'(cnt_o), 64'd0);
    check("rst_valid", 64'(tc_valid), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic clean();
    en = 0; clr = '1; tc_ready = 1; bypass = '0; qual = '0;
    tick();
    clr = '0;
    tick();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    async_reset();

    // Hold on nonzero qualifier, then count.
    en = 1; qual = 6'h04;
    repeat (10) tick();
    check("hold_cnt", 64'(cnt_o), 64'd0);
    qual = 0;
    repeat (3) tick();
    check("count_ch0", 64'(cnt_o[7:0]), 64'd3);

    // Asynchronous reset mid-count.
    async_reset();

    // Wrap event on ch1 (preset to all-ones via bypass).
    clean();
    en = 1; bypass = 4'b0010; tick();
    bypass = 0; tc_ready = 1; tick();
    check("wrap_valid0", 64'(tc_valid), 64'd0);
    en = 0; tick();
`ifndef COUNTER_SAT_EN
    check("wrap_cnt1", 64'(cnt_o[15:8]), 64'd0);
    check("wrap_valid", 64'(tc_valid), 64'd1);
    check("wrap_ch", 64'(tc_ch), 64'd1);
`endif
    tick();
    check("wrap_single", 64'(tc_valid), 64'd0);

    // ch0 and ch3 wrap together with consumer stalled.
    clean();
    en = 1; bypass = 4'b1001; tick();
    bypass = 0; tc_ready = 0; tick();
    en = 0;
    repeat (3) tick();
`ifndef COUNTER_SAT_EN
    check("prio_ch0", 64'(tc_ch), 64'd0);
`endif
    tc_ready = 1;
    repeat (3) tick();

    // ch2 wraps repeatedly while stalled -> overflow, then clear.
    clean();
    tc_ready = 0; en = 1;
    repeat (3) begin
      bypass = 4'b0100; tick();
      bypass = 0; tick();
    end
`ifndef COUNTER_SAT_EN
    check("ovf2", 64'(ovf_o[2]), 64'd1);
`endif
    en = 0; clr = 4'b0100; tick();
    clr = 0;
    check("ovf2_clr", 64'(ovf_o[2]), 64'd0);
    check("cnt2_clr", 64'(cnt_o[23:16]), 64'd0);

    // Bypass inverts 0F to F0 without an event.
    clean();
    en = 1;
    repeat (15) tick();
    bypass = 4'b0001; tick();
    bypass = 0; en = 0;
    check("byp_cnt0", 64'(cnt_o[7:0]), 64'hF0);
    tick();
    check("byp_noev", 64'(tc_valid), 64'd0);

`ifdef COUNTER_SAT_EN
    // Saturation: FE -> FF with one event, then hold.
    clean();
    en = 1; tick();
    bypass = 4'b0001; tick();
    bypass = 0; tick();
    check("sat_ff", 64'(cnt_o[7:0]), 64'hFF);
    tick();
    check("sat_hold", 64'(cnt_o[7:0]), 64'hFF);
    check("sat_ev", 64'(tc_valid), 64'd1);
    en = 0; tick();
    check("sat_noev", 64'(tc_valid), 64'd0);
`endif

    // Randomized phase.
    clean();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 10) != 0;
      qual = (($urandom % 5) == 0) ? QUAL_W'($urandom) : '0;
      for (int c = 0; c < NCH; c++) begin
        clr[c] = ($urandom % 50) == 0;
        bypass[c] = ($urandom % 8) == 0;
      end
      tc_ready = ($urandom % 10) < 6;
      if (i == 1500) async_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
